// File: rtl/warr_vector_linear_mport_pkg.sv
// Shared types and constants for the multi-lane Q16.16 vector-matrix linear engine.
package warr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int FRAC_BITS = 16;
  localparam int LAT       = 4;

  function automatic int row_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/warr_vector_linear_mport_if.sv
// Weight/bias memory port: the engine (master) issues row reads, the memory (slave)
// returns one weight row and one bias word per lane a cycle later.
interface warr_vector_linear_mport_if #(
  parameter int NPORT = 2,
  parameter int VLEN  = 32,
  parameter int NROW  = 96,
  parameter int DW    = 32
);
  import warr_pkg::*;

  localparam int AW = row_aw(NROW);

  logic                               w_rd_en;
  logic [NPORT-1:0][AW-1:0]           w_addr;
  logic [NPORT-1:0][VLEN-1:0][DW-1:0] w_data;
  logic [NPORT-1:0][DW-1:0]           b_data;

  modport master (output w_rd_en, output w_addr, input w_data, input b_data);
  modport slave  (input w_rd_en, input w_addr, output w_data, output b_data);

endinterface

// File: rtl/warr_vector_linear_mport_vec_dot_lane.sv
// One dot-product lane: multiply, adder tree, bias add with round-half-up and reduction
// to DW bits. Reduction saturates when WARR_SATURATE_EN is defined, otherwise wraps.
module vec_dot_lane
  import warr_pkg::*;
#(
  parameter int VLEN = 32,
  parameter int DW   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_p1,
  input  logic                      en_p2,
  input  logic                      en_p3,
  input  logic [VLEN-1:0][DW-1:0]   x_p1,
  input  logic [VLEN-1:0][DW-1:0]   w_p1,
  input  logic [DW-1:0]             b_p1,
  output logic signed [DW-1:0]      y_p4
);

  localparam int PW = 2 * DW;
  localparam int SW = 2 * DW + $clog2(VLEN) + 2;

  logic signed [PW-1:0] prod_d  [VLEN];
  logic signed [PW-1:0] prod_p2 [VLEN];
  logic signed [DW-1:0] bias_p2;
  logic signed [SW-1:0] sum_d;
  logic signed [SW-1:0] sum_p3;
  logic signed [DW-1:0] bias_p3;

  function automatic logic signed [SW-1:0] round_q(input logic signed [SW-1:0] acc,
                                                   input logic signed [DW-1:0] b);
    logic signed [SW-1:0] t;
    t = acc + (SW'(b) <<< FRAC_BITS) + (SW'(1) <<< (FRAC_BITS - 1));
    return t >>> FRAC_BITS;
  endfunction

`ifdef WARR_SATURATE_EN
  localparam logic signed [SW-1:0] MAX_S = SW'({1'b0, {(DW-1){1'b1}}});
  localparam logic signed [SW-1:0] MIN_S = -MAX_S - SW'(1);

  function automatic logic [DW-1:0] reduce_dw(input logic signed [SW-1:0] v);
    if (v > MAX_S) return {1'b0, {(DW-1){1'b1}}};
    if (v < MIN_S) return {1'b1, {(DW-1){1'b0}}};
    return DW'(v);
  endfunction
`else
  function automatic logic [DW-1:0] reduce_dw(input logic signed [SW-1:0] v);
    return DW'(v);
  endfunction
`endif

  always_comb begin
    for (int k = 0; k < VLEN; k++) begin
      prod_d[k] = PW'($signed(x_p1[k])) * PW'($signed(w_p1[k]));
    end
  end

  // p1 -> p2: full-precision products
  always_ff @(posedge clk) begin
    if (en_p1) begin
      for (int k = 0; k < VLEN; k++) prod_p2[k] <= prod_d[k];
      bias_p2 <= $signed(b_p1);
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < VLEN; k++) sum_d = sum_d + SW'(prod_p2[k]);
  end

  // p2 -> p3: accumulated sum
  always_ff @(posedge clk) begin
    if (en_p2) begin
      sum_p3  <= sum_d;
      bias_p3 <= bias_p2;
    end
  end

  // p3 -> p4: bias, rounding and reduction; the result register is cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      y_p4 <= '0;
    end else if (en_p3) begin
      y_p4 <= reduce_dw(round_q(sum_p3, bias_p3));
    end
  end

endmodule

// File: rtl/warr_vector_linear_mport.sv
// NPORT-lane linear layer: streams weight rows from memory and emits biased, rounded
// Q16.16 dot products. Optional saturation via WARR_SATURATE_EN (see vec_dot_lane).
module warr_vector_linear_mport
  import warr_pkg::*;
#(
  parameter int NPORT = 2,
  parameter int VLEN  = 32,
  parameter int NROW  = 96,
  parameter int DW    = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [row_aw(NROW)-1:0]               row_base,
  input  logic [row_aw(NROW):0]                 iter_count,
  input  logic [NPORT-1:0][VLEN-1:0][DW-1:0]    din,
  output logic                                  busy,
  warr_vector_linear_mport_if.master            mem,
  output logic                                  out_valid,
  output logic [NPORT-1:0][row_aw(NROW)-1:0]    out_row,
  output logic [NPORT-1:0][DW-1:0]              dout,
  output logic                                  done
);

  localparam int AW = row_aw(NROW);
  localparam int IW = AW + 1;

  state_t                              state_q, state_d;
  logic [IW-1:0]                       j_q, j_d;
  logic [IW-1:0]                       iter_q;
  logic                                rd_en_q, rd_en_d;
  logic [NPORT-1:0][AW-1:0]            addr_q, addr_d;
  logic                                accept, zero_done, last_p0;
  logic                                done_q;
  logic [LAT:1]                        vld_q;
  logic [LAT-1:1]                      last_q;
  logic [NPORT-1:0][AW-1:0]            row_q [1:LAT];
  logic [NPORT-1:0][VLEN-1:0][DW-1:0]  din_q;

  // Row addresses never exceed NROW-1 before the add, so one conditional subtract wraps them.
  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] a, input int inc);
    int s;
    s = int'(a) + inc;
    if (s >= NROW) s = s - NROW;
    return AW'(s);
  endfunction

  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    rd_en_d   = 1'b0;
    addr_d    = addr_q;
    accept    = 1'b0;
    zero_done = 1'b0;
    last_p0   = (state_q == RUN) && (j_q == iter_q - IW'(1));
    unique case (state_q)
      IDLE: begin
        if (start && (iter_count != '0)) begin
          accept  = 1'b1;
          state_d = RUN;
          rd_en_d = 1'b1;
          j_d     = '0;
          for (int p = 0; p < NPORT; p++) addr_d[p] = wrap_add(row_base, p);
        end else if (start) begin
          zero_done = 1'b1;
        end
      end
      RUN: begin
        if (last_p0) begin
          state_d = DRAIN;
        end else begin
          rd_en_d = 1'b1;
          j_d     = j_q + IW'(1);
          for (int p = 0; p < NPORT; p++) addr_d[p] = wrap_add(addr_q[p], NPORT);
        end
      end
      DRAIN: begin
        if (done_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // p0 issue -> p1..pLAT: valid, last-row flag and row index travel with the lane data
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      j_q     <= '0;
      iter_q  <= '0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      vld_q   <= '0;
      last_q  <= '0;
      done_q  <= 1'b0;
      for (int s = 1; s <= LAT; s++) row_q[s] <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      if (accept) iter_q <= iter_count;
      vld_q   <= {vld_q[LAT-1:1], rd_en_q};
      last_q  <= {last_q[LAT-2:1], last_p0};
      done_q  <= zero_done | (vld_q[LAT-1] & last_q[LAT-1]);
      row_q[1] <= addr_q;
      for (int s = 2; s <= LAT; s++) row_q[s] <= row_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) din_q <= din;
  end

  for (genvar p = 0; p < NPORT; p++) begin : g_lane
    vec_dot_lane #(
      .VLEN (VLEN),
      .DW   (DW)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en_p1 (vld_q[1]),
      .en_p2 (vld_q[2]),
      .en_p3 (vld_q[3]),
      .x_p1  (din_q[p]),
      .w_p1  (mem.w_data[p]),
      .b_p1  (mem.b_data[p]),
      .y_p4  (dout[p])
    );
  end

  assign mem.w_rd_en = rd_en_q;
  assign mem.w_addr  = addr_q;
  assign busy        = (state_q != IDLE);
  assign out_valid   = vld_q[LAT];
  assign out_row     = row_q[LAT];
  assign done        = done_q;

endmodule

// File: tb/tb_warr_vector_linear_mport.sv
// Bench for warr_vector_linear_mport: directed and randomized jobs checked cycle by cycle
// against an arithmetic model of the layer and its issue/result timing.
module tb_warr_vector_linear_mport;

  localparam int NPORT = 2;
  localparam int VLEN  = 32;
  localparam int NROW  = 96;
  localparam int DW    = 32;
  localparam int AW    = $clog2(NROW);

  logic                               clk = 1'b0;
  logic                               rst;
  logic                               start;
  logic [AW-1:0]                      row_base;
  logic [AW:0]                        iter_count;
  logic [NPORT-1:0][VLEN-1:0][DW-1:0] din;
  logic [NPORT-1:0][VLEN-1:0][DW-1:0] din_v;
  logic                               busy;
  logic                               out_valid;
  logic [NPORT-1:0][AW-1:0]           out_row;
  logic [NPORT-1:0][DW-1:0]           dout;
  logic                               done;

  logic [VLEN-1:0][DW-1:0]            wmem [NROW];
  logic [DW-1:0]                      bmem [NROW];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  warr_vector_linear_mport_if #(.NPORT(NPORT), .VLEN(VLEN), .NROW(NROW), .DW(DW)) mif ();

  warr_vector_linear_mport #(.NPORT(NPORT), .VLEN(VLEN), .NROW(NROW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .row_base   (row_base),
    .iter_count (iter_count),
    .din        (din),
    .busy       (busy),
    .mem        (mif),
    .out_valid  (out_valid),
    .out_row    (out_row),
    .dout       (dout),
    .done       (done)
  );

  // Weight/bias memory with one cycle read latency
  always @(posedge clk) begin
    if (mif.w_rd_en) begin
      for (int p = 0; p < NPORT; p++) begin
        mif.w_data[p] <= wmem[mif.w_addr[p]];
        mif.b_data[p] <= bmem[mif.w_addr[p]];
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd(input int mode, input logic [DW-1:0] c);
    if (mode == 0) return c;
    if (mode == 1) return DW'($urandom_range(0, 32'h0008_0000) - 32'h0004_0000);
    return DW'($urandom);
  endfunction

  task automatic set_data(input int mode, input logic [DW-1:0] dc, input logic [DW-1:0] wc,
                          input logic [DW-1:0] bc);
    for (int r = 0; r < NROW; r++) begin
      for (int k = 0; k < VLEN; k++) wmem[r][k] = rnd(mode, wc);
      bmem[r] = rnd(mode, bc);
    end
    for (int p = 0; p < NPORT; p++)
      for (int k = 0; k < VLEN; k++) din_v[p][k] = rnd(mode, dc);
  endtask

  // Exact dot product plus bias, round half up at bit 16, then reduce to DW bits
  function automatic logic [DW-1:0] ref_dot(input int p, input int r);
    logic signed [127:0] acc;
    acc = 128'($signed(bmem[r])) * 128'sd65536 + 128'sd32768;
    for (int k = 0; k < VLEN; k++)
      acc = acc + 128'($signed(din_v[p][k])) * 128'($signed(wmem[r][k]));
    acc = acc >>> 16;
`ifdef WARR_SATURATE_EN
    if (acc > 128'sd2147483647) return 32'h7FFF_FFFF;
    if (acc < -128'sd2147483648) return 32'h8000_0000;
`endif
    return acc[DW-1:0];
  endfunction

  task automatic chk_idle_outputs(input string nm);
    chk({nm, ":busy"}, 128'(busy), 128'(0));
    chk({nm, ":rd_en"}, 128'(mif.w_rd_en), 128'(0));
    chk({nm, ":out_valid"}, 128'(out_valid), 128'(0));
    chk({nm, ":done"}, 128'(done), 128'(0));
    chk({nm, ":dout"}, 128'(dout), 128'(0));
    chk({nm, ":out_row"}, 128'(out_row), 128'(0));
    chk({nm, ":w_addr"}, 128'(mif.w_addr), 128'(0));
  endtask

  // Cycle k after acceptance: issue j=k-1 for k<=iters, result j at k=j+5, done at the last result
  task automatic run_job(input string nm, input int base, input int iters, input bit poke);
    int  last_k;
    bit  iss, ov;
    int  r;
    last_k = (iters == 0) ? 1 : iters + 4;
    @(negedge clk);
    din        = din_v;
    row_base   = AW'(base);
    iter_count = (AW + 1)'(iters);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= last_k + 2; k++) begin
      if (poke && k == 3) begin
        start      = 1'b1;
        iter_count = (AW + 1)'(5);
        row_base   = AW'(7);
        din        = ~din_v;
      end
      if (poke && k == 4) start = 1'b0;
      iss = (iters > 0) && (k <= iters);
      ov  = (iters > 0) && (k >= 5) && (k <= iters + 4);
      chk({nm, ":busy"}, 128'(busy), 128'((iters > 0) && (k <= last_k)));
      chk({nm, ":rd_en"}, 128'(mif.w_rd_en), 128'(iss));
      chk({nm, ":out_valid"}, 128'(out_valid), 128'(ov));
      chk({nm, ":done"}, 128'(done), 128'(k == last_k));
      if (iss) begin
        for (int p = 0; p < NPORT; p++)
          chk({nm, ":w_addr"}, 128'(mif.w_addr[p]), 128'((base + (k - 1) * NPORT + p) % NROW));
      end
      if (ov) begin
        for (int p = 0; p < NPORT; p++) begin
          r = (base + (k - 5) * NPORT + p) % NROW;
          chk({nm, ":out_row"}, 128'(out_row[p]), 128'(r));
          chk({nm, ":dout"}, 128'(dout[p]), 128'(ref_dot(p, r)));
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    row_base   = '0;
    iter_count = '0;
    din        = '0;
    din_v      = '0;
    set_data(1, '0, '0, '0);
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;

    set_data(0, 32'h0001_0000, 32'h0001_0000, 32'h0);
    run_job("s1_ones", 0, 48, 1'b0);

    set_data(1, '0, '0, '0);
    run_job("s2_wrap", 94, 2, 1'b0);
    run_job("s3_zero", 5, 0, 1'b0);

    set_data(1, '0, '0, '0);
    run_job("s4_busy_start", 10, 6, 1'b1);

    set_data(0, 32'h7FFF_0000, 32'h0002_0000, 32'h0);
    run_job("s5_ovf", 0, 3, 1'b0);
    set_data(0, 32'h8000_0000, 32'h0002_0000, 32'h0);
    run_job("s5_ovf_neg", 50, 2, 1'b0);
    set_data(2, '0, '0, '0);
    run_job("s5_full_rand", 40, 4, 1'b0);

    for (int n = 0; n < 4; n++) begin
      set_data(1, '0, '0, '0);
      run_job("rand_job", int'($urandom_range(0, NROW - 1)), int'($urandom_range(1, 12)), 1'b0);
    end

    set_data(1, '0, '0, '0);
    @(negedge clk);
    din        = din_v;
    row_base   = AW'(20);
    iter_count = (AW + 1)'(10);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_outputs("s6_abort");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 14; k++) begin
      chk("s6_after:out_valid", 128'(out_valid), 128'(0));
      chk("s6_after:done", 128'(done), 128'(0));
      chk("s6_after:rd_en", 128'(mif.w_rd_en), 128'(0));
      @(negedge clk);
    end
    set_data(1, '0, '0, '0);
    run_job("s6_restart", 3, 5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/warr_vector_linear_mport.md
WARR_VECTOR_LINEAR_MPORT -- requirements
Module: warr_vector_linear_mport

Interface
REQ-001 Parameters SHALL be: NPORT, default 2, number of parallel dot-product lanes.
REQ-002 VLEN, default 32, input vector length.
REQ-003 NROW, default 96, weight-matrix rows.
REQ-004 DW, default 32, data width (signed Q16.16).
REQ-005 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
REQ-006 Control ports SHALL be:
- start  in  1  request pulse.
- row_base  in  $clog2(NROW)  first row.
- iter_count  in  $clog2(NROW)+1  iterations; each iteration computes NPORT rows.
- din  in  NPORT x VLEN x DW  per-lane input vectors, sampled on accepted start.
- busy  out  1  operation in progress.
REQ-007 Memory and result ports SHALL be:
- w_rd_en  out  1  weight/bias read strobe.
- w_addr  out  NPORT x $clog2(NROW)  row address per lane.
- w_data  in  NPORT x VLEN x DW  weight rows, valid 1 cycle after w_rd_en.
- b_data  in  NPORT x DW  bias per lane, valid 1 cycle after w_rd_en.
- out_valid  out  1  results valid.
- out_row  out  NPORT x $clog2(NROW)  row index of each result.
- dout  out  NPORT x DW  results.
- done  out  1  one-cycle completion pulse.

Function
REQ-008 The FSM SHALL have states IDLE, RUN and DRAIN; all other states are unreachable.
REQ-009 IDLE->RUN SHALL occur on start with iter_count>0; din, row_base and iter_count are latched in that cycle.
REQ-010 start SHALL be ignored while busy; the latched vectors SHALL be held unchanged until return to IDLE.
REQ-011 start with iter_count==0 SHALL produce no reads and no out_valid, and SHALL pulse done in the following cycle while remaining in IDLE.
REQ-012 In RUN, iteration j (0..iter_count-1) SHALL be issued in the j-th cycle after start acceptance, with w_rd_en=1 and w_addr[p]=(row_base+j*NPORT+p) mod NROW.
REQ-013 RUN->DRAIN SHALL occur after the last issue; DRAIN->IDLE SHALL occur when the last result is emitted.
REQ-014 busy SHALL be 1 from the cycle after start acceptance through the done cycle inclusive.
REQ-015 Each lane SHALL compute dout[p] = sum_k(din[p][k]*w_data[p][k]) as a full-precision signed accumulation, then add bias<<16, shift right 16 with round-half-up, and reduce to DW bits.
REQ-016 Fixed latency SHALL be 4 cycles from issue to out_valid (memory, multiply, adder tree, bias/round); results SHALL emerge one per cycle in issue order, with out_row equal to the issued address.
REQ-017 done SHALL coincide with the last out_valid.
REQ-018 There is no backpressure: the consumer SHALL accept every out_valid cycle.

Reset
REQ-019 While rst is high, the FSM SHALL be in IDLE and busy, done, out_valid and w_rd_en SHALL be 0.
REQ-020 While rst is high, dout, out_row and w_addr SHALL be 0, and all pipeline valid bits SHALL be cleared.
REQ-021 Reset asserted mid-operation SHALL abort it; no out_valid and no done SHALL follow for the aborted job.

Configuration
REQ-022 With WARR_SATURATE_EN defined, the reduction to DW bits SHALL clamp to 0x7FFFFFFF or 0x80000000 on overflow.
REQ-023 With WARR_SATURATE_EN undefined, the reduction to DW bits SHALL truncate to the low DW bits (two's-complement wrap).

Structure
REQ-024 Package warr_pkg SHALL hold the state enum (IDLE/RUN/DRAIN), FRAC_BITS=16, LAT=4, and the row-address width function.
REQ-025 The sub-module vec_dot_lane (one per lane, generate loop) SHALL implement multiply, adder tree and bias/round; the FSM and address generation remain in the top module.

Verification
REQ-026 Directed scenarios:
- Scenario 1: start, row_base=0, iter_count=48, din=all 1.0, weights=1.0, bias=0 -> 48 out_valid cycles with dout=32.0 (0x00200000), out_row pairs 0/1..94/95, done on the 48th.
- Scenario 2: row_base=94, iter_count=2 -> w_addr {94,95} then {0,1} (wrap).
- Scenario 3: start with iter_count=0 -> done 1 cycle later, no w_rd_en, no out_valid.
- Scenario 4: second start during busy -> ignored; result count and vectors unchanged.
- Scenario 5: din=0x7FFF0000 everywhere, weight=2.0 -> 0x7FFFFFFF with WARR_SATURATE_EN, truncated value without it.
- Scenario 6: rst asserted 2 cycles into a 10-iteration job -> outputs 0 next cycle, no further out_valid/done; a new start afterwards completes normally.
